// File: rtl/dm_load_unit_pkg.sv
// Shared definitions for the data-memory load unit: wordmode codes,
// exception codes, state encoding and the alignment / byte-lane helpers.
package dm_load_unit_pkg;

   localparam logic [2:0] WM_WD = 3'd0;
   localparam logic [2:0] WM_HU = 3'd2;
   localparam logic [2:0] WM_HS = 3'd3;
   localparam logic [2:0] WM_BU = 3'd4;
   localparam logic [2:0] WM_BS = 3'd5;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_DBE  = 5'd7;

   typedef enum logic [1:0] {
      LS_IDLE = 2'd0,
      LS_WAIT = 2'd1,
      LS_RESP = 2'd2
   } ls_state_e;

   // Unknown wordmode codes behave as full-word loads.
   function automatic logic is_misaligned(input logic [1:0] lo, input logic [2:0] wm);
      logic mis;
      case (wm)
         WM_HU, WM_HS: mis = lo[0];
         WM_BU, WM_BS: mis = 1'b0;
         default:      mis = (lo != 2'b00);
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] lo, input logic [2:0] wm);
      logic [3:0] be;
      case (wm)
         WM_HU, WM_HS: be = lo[1] ? 4'b1100 : 4'b0011;
         WM_BU, WM_BS: be = 4'b0001 << lo;
         default:      be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dm_load_unit_load_ext.sv
// Load data lane selection and sign/zero extension (purely combinational).
module dm_load_unit_load_ext
   import dm_load_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  wordmode,
   output logic [31:0] data
);

   logic [15:0] half_s;
   logic [7:0]  byte_s;

   // Pick the addressed halfword and byte lanes.
   always_comb begin
      half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      byte_s = rdata[{addr_lo, 3'b000} +: 8];
   end

   // Extend the selected lane according to the wordmode.
   always_comb begin
      case (wordmode)
         WM_HU:   data = {16'h0000, half_s};
         WM_HS:   data = {{16{half_s[15]}}, half_s};
         WM_BU:   data = {24'h00_0000, byte_s};
         WM_BS:   data = {{24{byte_s[7]}}, byte_s};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/dm_load_unit.sv
// Single-outstanding load unit: MEM-stage request -> memory read -> extended WB response.
// Optional read timeout (bus error) enabled by defining LOAD_TIMEOUT_EN.
module dm_load_unit
   import dm_load_unit_pkg::*;
`ifdef LOAD_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 5
)
`endif
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_wordmode,
   input  logic [4:0]  req_rd,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_exc,
   output logic [4:0]  resp_exccode
);

   ls_state_e   state_r;
   logic [1:0]  addr_lo_r;
   logic [2:0]  wm_r;
   logic        resp_valid_r;
   logic [31:0] resp_data_r;
   logic [4:0]  resp_rd_r;
   logic        resp_exc_r;
   logic [4:0]  resp_exccode_r;
   logic        accept_s;
   logic        mis_s;
   logic        rd_en_s;
   logic [31:0] ext_data_s;
`ifdef LOAD_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_r;
`endif

   assign accept_s  = req_valid & (state_r == LS_IDLE);
   assign mis_s     = is_misaligned(req_addr[1:0], req_wordmode);
   assign rd_en_s   = accept_s & ~mis_s;
   assign req_ready = (state_r == LS_IDLE);
   assign mem_rd_en = rd_en_s;
   assign mem_addr  = rd_en_s ? {req_addr[31:2], 2'b00} : 32'd0;
   assign mem_be    = rd_en_s ? lane_be(req_addr[1:0], req_wordmode) : 4'b0000;

   // Lane selection uses the address captured at accept, not the live request.
   dm_load_unit_load_ext u_load_ext (
      .rdata    (mem_rdata),
      .addr_lo  (addr_lo_r),
      .wordmode (wm_r),
      .data     (ext_data_s)
   );

   // Load control FSM with registered response outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r        <= LS_IDLE;
         addr_lo_r      <= 2'b00;
         wm_r           <= 3'd0;
         resp_valid_r   <= 1'b0;
         resp_data_r    <= 32'd0;
         resp_rd_r      <= 5'd0;
         resp_exc_r     <= 1'b0;
         resp_exccode_r <= 5'd0;
`ifdef LOAD_TIMEOUT_EN
         cnt_r          <= '0;
`endif
      end else begin
         case (state_r)
            LS_IDLE: begin
               if (accept_s) begin
                  addr_lo_r <= req_addr[1:0];
                  wm_r      <= req_wordmode;
                  resp_rd_r <= req_rd;
                  if (mis_s) begin
                     state_r        <= LS_RESP;
                     resp_valid_r   <= 1'b1;
                     resp_data_r    <= 32'd0;
                     resp_exc_r     <= 1'b1;
                     resp_exccode_r <= EXC_ADEL;
                  end else begin
                     state_r <= LS_WAIT;
`ifdef LOAD_TIMEOUT_EN
                     cnt_r   <= '0;
`endif
                  end
               end
            end
            LS_WAIT: begin
               // Returned data takes priority over a timeout in the same cycle.
               if (mem_rvalid) begin
                  state_r        <= LS_RESP;
                  resp_valid_r   <= 1'b1;
                  resp_data_r    <= ext_data_s;
                  resp_exc_r     <= 1'b0;
                  resp_exccode_r <= 5'd0;
               end
`ifdef LOAD_TIMEOUT_EN
               else if (cnt_r == CNT_W'(TIMEOUT_CYCLES)) begin
                  state_r        <= LS_RESP;
                  resp_valid_r   <= 1'b1;
                  resp_data_r    <= 32'd0;
                  resp_exc_r     <= 1'b1;
                  resp_exccode_r <= EXC_DBE;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
`endif
            end
            LS_RESP: begin
               if (resp_ready) begin
                  state_r      <= LS_IDLE;
                  resp_valid_r <= 1'b0;
               end
            end
            default: begin
               state_r      <= LS_IDLE;
               resp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign resp_valid   = resp_valid_r;
   assign resp_data    = resp_data_r;
   assign resp_rd      = resp_rd_r;
   assign resp_exc     = resp_exc_r;
   assign resp_exccode = resp_exccode_r;

endmodule

// File: tb/tb_dm_load_unit.sv
// Scoreboard bench for dm_load_unit: directed loads push expected responses,
// a monitor pops and compares them on every response handshake.
module tb_dm_load_unit;
   import dm_load_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = 32'd0;
   logic [2:0]  req_wordmode = 3'd0;
   logic [4:0]  req_rd = 5'd0;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_rvalid = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_exc;
   logic [4:0]  resp_exccode;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        exc;
      logic [4:0]  code;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   dm_load_unit dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wordmode(req_wordmode), .req_rd(req_rd),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_exc(resp_exc), .resp_exccode(resp_exccode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: just before each rising edge, a valid&ready response is compared.
   always @(negedge clk) begin
      #4;
      if (reset && resp_valid && resp_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: got data 0x%08h with empty scoreboard", resp_data);
         end else begin
            mon_e = sb_q.pop_front();
            chk("resp_data", resp_data, mon_e.data);
            chk("resp_rd", 32'(resp_rd), 32'(mon_e.rd));
            chk("resp_exc", 32'(resp_exc), 32'(mon_e.exc));
            chk("resp_exccode", 32'(resp_exccode), 32'(mon_e.code));
         end
      end
   end

   task automatic issue(input logic [31:0] addr, input logic [2:0] wm, input logic [4:0] rd,
                        input logic early_rv);
      @(negedge clk);
      req_valid    = 1'b1;
      req_addr     = addr;
      req_wordmode = wm;
      req_rd       = rd;
      mem_rvalid   = early_rv;
      mem_rdata    = 32'hDEAD_BEEF;
      #1;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
   endtask

   task automatic load_ok(input logic [31:0] addr, input logic [2:0] wm, input logic [4:0] rd,
                          input logic [31:0] rdata, input int dly, input logic [3:0] be,
                          input logic [31:0] exp_data, input logic early_rv);
      issue(addr, wm, rd, early_rv);
      chk("mem_rd_en", 32'(mem_rd_en), 32'd1);
      chk("mem_be", 32'(mem_be), 32'(be));
      chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
      sb_q.push_back('{data: exp_data, rd: rd, exc: 1'b0, code: 5'd0});
      for (int k = 1; k <= dly; k++) begin
         @(negedge clk);
         req_valid  = 1'b0;
         mem_rvalid = (k == dly);
         mem_rdata  = (k == dly) ? rdata : 32'hDEAD_BEEF;
         #1;
         chk("resp_valid_wait", 32'(resp_valid), 32'd0);
         chk("req_ready_wait", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      chk("resp_valid_resp", 32'(resp_valid), 32'd1);
      @(negedge clk);
      #1;
      chk("resp_valid_after", 32'(resp_valid), 32'd0);
      chk("req_ready_after", 32'(req_ready), 32'd1);
   endtask

   task automatic load_mis(input logic [31:0] addr, input logic [2:0] wm, input logic [4:0] rd);
      issue(addr, wm, rd, 1'b0);
      chk("mis_mem_rd_en", 32'(mem_rd_en), 32'd0);
      chk("mis_mem_be", 32'(mem_be), 32'd0);
      sb_q.push_back('{data: 32'd0, rd: rd, exc: 1'b1, code: EXC_ADEL});
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("mis_resp_valid", 32'(resp_valid), 32'd1);
      @(negedge clk);
      #1;
      chk("mis_resp_valid_after", 32'(resp_valid), 32'd0);
      chk("mis_req_ready_after", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_exccode", 32'(resp_exccode), 32'd0);
      chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      load_ok(32'h0000_0013, WM_BS, 5'd3, 32'h80FF_7F01, 1, 4'b1000, 32'hFFFF_FF80, 1'b0);
      load_ok(32'h0000_0002, WM_HU, 5'd4, 32'h8001_1234, 1, 4'b1100, 32'h0000_8001, 1'b0);
      load_ok(32'h0000_0002, WM_HS, 5'd5, 32'h8001_1234, 1, 4'b1100, 32'hFFFF_8001, 1'b0);
      load_ok(32'h0000_0100, WM_HS, 5'd6, 32'h8001_1234, 3, 4'b0011, 32'h0000_1234, 1'b0);
      load_ok(32'h0000_0011, WM_BS, 5'd7, 32'h80FF_7F01, 2, 4'b0010, 32'h0000_007F, 1'b1);
      load_ok(32'h0000_0012, WM_BS, 5'd8, 32'h80FF_7F01, 1, 4'b0100, 32'hFFFF_FFFF, 1'b0);
      load_ok(32'h0000_0013, WM_BU, 5'd9, 32'h80FF_7F01, 1, 4'b1000, 32'h0000_0080, 1'b0);
      load_ok(32'h0000_0004, 3'd7, 5'd10, 32'hA5A5_0F0F, 1, 4'b1111, 32'hA5A5_0F0F, 1'b0);
      load_mis(32'h0000_0006, WM_WD, 5'd12);
      load_mis(32'h0000_0001, WM_HU, 5'd13);

      // Stray read data while idle must not produce a response.
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1111_2222;
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      chk("stray_resp_valid", 32'(resp_valid), 32'd0);

      // Back-pressure: response held stable while resp_ready is low.
      resp_ready = 1'b0;
      issue(32'h0000_0020, WM_WD, 5'd9, 1'b0);
      chk("stall_mem_be", 32'(mem_be), 32'hF);
      sb_q.push_back('{data: 32'h1234_5678, rd: 5'd9, exc: 1'b0, code: 5'd0});
      @(negedge clk);
      req_valid  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234_5678;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         #1;
         chk("stall_resp_valid", 32'(resp_valid), 32'd1);
         chk("stall_resp_data", resp_data, 32'h1234_5678);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         chk("stall_mem_rd_en", 32'(mem_rd_en), 32'd0);
      end
      @(negedge clk);
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("stall_release_valid", 32'(resp_valid), 32'd0);
      chk("stall_release_ready", 32'(req_ready), 32'd1);

      // Reset during WAIT aborts the load; the late read data is ignored.
      issue(32'h0000_0040, WM_WD, 5'd11, 1'b0);
      chk("abort_mem_rd_en", 32'(mem_rd_en), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      reset     = 1'b0;
      #1;
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h55AA_55AA;
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      chk("abort_late_valid", 32'(resp_valid), 32'd0);
      chk("abort_late_ready", 32'(req_ready), 32'd1);

`ifdef LOAD_TIMEOUT_EN
      // No read data: bus error 17 cycles after entering WAIT.
      issue(32'h0000_0080, WM_WD, 5'd13, 1'b0);
      sb_q.push_back('{data: 32'd0, rd: 5'd13, exc: 1'b1, code: EXC_DBE});
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         if (resp_valid) begin
            lat = k;
            break;
         end
      end
      chk("timeout_latency", 32'(lat), 32'd18);
      @(negedge clk);
      #1;
      chk("timeout_after", 32'(resp_valid), 32'd0);

      // Read data in the timeout cycle wins over the bus error.
      issue(32'h0000_0084, WM_WD, 5'd14, 1'b0);
      sb_q.push_back('{data: 32'hCAFE_F00D, rd: 5'd14, exc: 1'b0, code: 5'd0});
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         req_valid  = 1'b0;
         mem_rvalid = (k == 17);
         mem_rdata  = (k == 17) ? 32'hCAFE_F00D : 32'hDEAD_BEEF;
         #1;
         if (resp_valid) begin
            lat = k;
            break;
         end
      end
      mem_rvalid = 1'b0;
      chk("timeout_race_latency", 32'(lat), 32'd18);
      @(negedge clk);
      #1;
      chk("timeout_race_after", 32'(resp_valid), 32'd0);
`else
      lat = 0;
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dm_load_unit.md
Name: dm_load_unit

Overview:
- Load-side counterpart of the store byte-enable decoder.
- Accepts one load request from the MEM stage and issues a read to data memory or the bridge.
- Waits for read data, then selects the addressed byte or halfword lane and sign- or zero-extends it.
- Returns the result, or an exception code, to the WB stage through a valid/ready handshake. One outstanding load at a time.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT before a bus error is returned. Used only with LOAD_TIMEOUT_EN.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  load request present
- req_ready  out  1  unit can accept a request
- req_addr  in  32  byte address of the load
- req_wordmode  in  3  width/sign mode: `wm_wd, `wm_hu, `wm_hs, `wm_bu, `wm_bs
- req_rd  in  5  destination register number
- mem_rd_en  out  1  read strobe to memory or bridge
- mem_addr  out  32  word-aligned read address
- mem_be  out  4  byte lanes being read
- mem_rdata  in  32  read data
- mem_rvalid  in  1  read data valid, single-cycle pulse
- resp_valid  out  1  result available
- resp_ready  in  1  WB stage takes the result
- resp_data  out  32  extended load data
- resp_rd  out  5  destination register echoed from the request
- resp_exc  out  1  load raised an exception
- resp_exccode  out  5  4 = AdEL, 7 = DBE

Behaviour:
- Reset: every registered output is driven to 0 and the state goes to IDLE.
- States: IDLE, WAIT, RESP.
- req_ready = (state == IDLE).
- Accept condition: req_valid & req_ready in cycle N. The request's addr, wordmode and rd are registered at that edge.
- Misalignment:
  - `wm_wd with addr[1:0] != 0 is misaligned.
  - `wm_hu or `wm_hs with addr[0] != 0 is misaligned.
  - Bytes are never misaligned.
- Misaligned request: mem_rd_en stays 0. State goes IDLE->RESP. At N+1: resp_exc=1, resp_exccode=4, resp_data=0.
- Aligned request:
  - In cycle N, mem_rd_en=1, mem_addr={addr[31:2],2'b00}, and mem_be follows the store lane map: word 1111; half 0011 or 1100 by addr[1]; byte one-hot by addr[1:0]. These outputs are combinational from the request and are 0 when no request is accepted.
  - State goes IDLE->WAIT.
- WAIT:
  - mem_rvalid=1 captures the extended data. State goes WAIT->RESP, so resp_valid=1 on the next cycle.
  - With a synchronous RAM that raises mem_rvalid at N+1, resp_valid is seen at N+2.
  - mem_rvalid in the same cycle as the accept (N) is ignored.
- Extension, with lane selection using the registered address:
  - `wm_wd: resp_data = rdata.
  - `wm_hu / `wm_hs: the halfword at rdata[16*addr[1] +: 16], zero- or sign-extended from bit 15.
  - `wm_bu / `wm_bs: the byte at rdata[8*addr[1:0] +: 8], zero- or sign-extended from bit 7.
  - Any other wordmode code is treated as `wm_wd.
- RESP:
  - resp_valid=1. resp_data, resp_rd, resp_exc and resp_exccode stay stable until resp_valid & resp_ready.
  - On the handshake, state goes RESP->IDLE; resp_valid drops at the next edge.
  - req_ready stays 0 in RESP, so a request cannot be accepted in the handshake cycle. Minimum spacing is 3 cycles for aligned loads and 2 for misaligned ones.
- mem_rvalid in IDLE or RESP is ignored (stray or late response).
- Reset asserted mid-operation aborts immediately: state=IDLE, resp_valid=0. A later mem_rvalid for the aborted read is ignored.
- resp_ready held high: no stall cycles are added.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- Defined:
  - The counter clears on every entry to WAIT and increments every WAIT cycle without mem_rvalid.
  - When the count reaches TIMEOUT_CYCLES, state goes to RESP with resp_exc=1, resp_exccode=7, resp_data=0.
  - mem_rvalid and the timeout in the same cycle: data wins.
- Undefined: no counter is built and WAIT lasts until mem_rvalid arrives.

Decomposition:
- The wm_* codes stay in head.v.
- Add to head.v: EXC_ADEL=5'd4, EXC_DBE=5'd7, and the state encodings LS_IDLE, LS_WAIT, LS_RESP.
- One natural sub-module: load_ext, purely combinational (rdata, addr[1:0], wordmode -> extended data). It is instantiated once and tested on its own.

Test Plan:
- `wm_bs, addr 0x0000_0013, mem_rdata 0x80FF_7F01 returned at N+1 -> mem_be=1000, resp_data=0xFFFF_FF80, resp_valid at N+2, resp_exc=0.
- `wm_hu, addr 0x0000_0002, mem_rdata 0x8001_1234 -> mem_be=1100, resp_data=0x0000_8001. The same case with `wm_hs -> 0xFFFF_8001.
- `wm_wd, addr 0x0000_0006 -> mem_rd_en never 1; resp_valid at N+1 with resp_exc=1, resp_exccode=4, resp_data=0.
- resp_ready held 0 for 5 cycles with rdata 0x1234_5678 (`wm_wd) -> outputs stable and req_ready=0 throughout; the handshake returns to IDLE and req_ready=1 on the following cycle.
- reset pulsed low during WAIT, then mem_rvalid arrives 2 cycles later -> resp_valid stays 0 and state is IDLE.
- LOAD_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no mem_rvalid -> resp_valid 17 cycles after the WAIT entry, resp_exccode=7. A second run with mem_rvalid in the timeout cycle -> data returned and resp_exc=0.
